// File: rtl/crc16_frame_chk_pkg.sv
// Shared definitions for the CRC-16/CCITT frame checker and its transmit-side peers:
// polynomial, seed, checker state encoding and the 16-bit parallel CRC step.
package crc16_frame_chk_pkg;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DROP = 2'd2
   } chk_state_e;

   // One 16-bit word folded into the CRC, MSB first; unrolls to pure XOR logic.
   function automatic logic [15:0] crc16_d16_next(input logic [15:0] c, input logic [15:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 15; i >= 0; i--) begin
         if (r[15] ^ d[i]) begin
            r = {r[14:0], 1'b0} ^ CRC16_POLY;
         end else begin
            r = {r[14:0], 1'b0};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/crc16_d16_comb.sv
// Purely combinational CRC-16/CCITT step over one 16-bit word (MSB first).
module crc16_d16_comb
   import crc16_frame_chk_pkg::*;
(
   input  logic [15:0] crc_i,
   input  logic [15:0] dat_i,
   output logic [15:0] crc_o
);

   assign crc_o = crc16_d16_next(crc_i, dat_i);

endmodule

// File: rtl/crc16_frame_chk.sv
// Receive-side CRC-16 frame checker: recomputes the CRC over each frame, strips the
// trailing CRC word, forwards the payload one word late and strobes per-frame status.
// Optional failed-frame counter (err_cnt port) is built when CRC16_CHK_ERR_CNT_EN is defined.
module crc16_frame_chk
   import crc16_frame_chk_pkg::*;
#(
   parameter  int MAX_WORDS = 512,
   localparam int CNT_W     = $clog2(MAX_WORDS + 1)
)(
   input  logic        clk_sys,
   input  logic        rst_sys,
   input  logic [15:0] rx_din,
   input  logic        rx_vld,
   input  logic        rx_sop,
   input  logic        rx_eop,
   output logic [15:0] pl_dout,
   output logic        pl_vld,
   output logic        pl_sop,
   output logic        pl_eop,
   output logic        chk_done,
   output logic        chk_ok,
   output logic        chk_err_len
`ifdef CRC16_CHK_ERR_CNT_EN
   ,
   output logic [15:0] err_cnt
`endif
);

   // Count value of the last word a frame may carry without being its CRC word.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS - 1);

   chk_state_e       state_q, state_d;
   logic [15:0]      crc_q, crc_d;
   logic [15:0]      hold_q, hold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sop_pend_q, sop_pend_d;   // next emission is the first of its frame

   logic [15:0]      pl_dout_q, pl_dout_d;
   logic             pl_vld_q, pl_vld_d;
   logic             pl_sop_q, pl_sop_d;
   logic             pl_eop_q, pl_eop_d;
   logic             done_q, done_d;
   logic             ok_q, ok_d;
   logic             err_len_q, err_len_d;

   logic [15:0]      crc_run;    // running CRC advanced by the incoming word
   logic [15:0]      crc_start;  // fresh CRC seeded by the incoming word

   crc16_d16_comb u_crc_run (
      .crc_i (crc_q),
      .dat_i (rx_din),
      .crc_o (crc_run)
   );

   crc16_d16_comb u_crc_start (
      .crc_i (CRC16_INIT),
      .dat_i (rx_din),
      .crc_o (crc_start)
   );

   // Next-state and output decode; only accepted words (rx_vld) move anything.
   always_comb begin
      state_d    = state_q;
      crc_d      = crc_q;
      hold_d     = hold_q;
      cnt_d      = cnt_q;
      sop_pend_d = sop_pend_q;
      pl_dout_d  = pl_dout_q;
      pl_vld_d   = 1'b0;
      pl_sop_d   = 1'b0;
      pl_eop_d   = 1'b0;
      done_d     = 1'b0;
      ok_d       = 1'b0;
      err_len_d  = 1'b0;
      if (rx_vld) begin
         case (state_q)
            ST_IDLE, ST_DROP: begin
               if (rx_sop) begin
                  if (rx_eop) begin
                     // A lone word cannot hold payload plus CRC.
                     done_d    = 1'b1;
                     err_len_d = 1'b1;
                     state_d   = ST_IDLE;
                  end else begin
                     crc_d      = crc_start;
                     hold_d     = rx_din;
                     cnt_d      = CNT_W'(1);
                     sop_pend_d = 1'b1;
                     state_d    = ST_RUN;
                  end
               end else if (rx_eop && state_q == ST_DROP) begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               // Every accepted word releases the previously held one.
               pl_vld_d   = 1'b1;
               pl_dout_d  = hold_q;
               pl_sop_d   = sop_pend_q;
               sop_pend_d = 1'b0;
               crc_d      = crc_run;
               hold_d     = rx_din;
               cnt_d      = cnt_q + CNT_W'(1);
               if (rx_sop) begin
                  // Unterminated frame: close it as a length error.
                  pl_eop_d  = 1'b1;
                  done_d    = 1'b1;
                  err_len_d = 1'b1;
                  if (rx_eop) begin
                     state_d = ST_IDLE;
                  end else begin
                     crc_d      = crc_start;
                     cnt_d      = CNT_W'(1);
                     sop_pend_d = 1'b1;
                  end
               end else if (rx_eop) begin
                  pl_eop_d = 1'b1;
                  done_d   = 1'b1;
                  ok_d     = (crc_run == 16'h0000);
                  state_d  = ST_IDLE;
               end else if (cnt_q == LAST_CNT) begin
                  pl_eop_d  = 1'b1;
                  done_d    = 1'b1;
                  err_len_d = 1'b1;
                  state_d   = ST_DROP;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State, CRC accumulator and registered outputs.
   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         state_q    <= ST_IDLE;
         crc_q      <= CRC16_INIT;
         hold_q     <= 16'h0000;
         cnt_q      <= '0;
         sop_pend_q <= 1'b0;
         pl_dout_q  <= 16'h0000;
         pl_vld_q   <= 1'b0;
         pl_sop_q   <= 1'b0;
         pl_eop_q   <= 1'b0;
         done_q     <= 1'b0;
         ok_q       <= 1'b0;
         err_len_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         crc_q      <= crc_d;
         hold_q     <= hold_d;
         cnt_q      <= cnt_d;
         sop_pend_q <= sop_pend_d;
         pl_dout_q  <= pl_dout_d;
         pl_vld_q   <= pl_vld_d;
         pl_sop_q   <= pl_sop_d;
         pl_eop_q   <= pl_eop_d;
         done_q     <= done_d;
         ok_q       <= ok_d;
         err_len_q  <= err_len_d;
      end
   end

   assign pl_dout     = pl_dout_q;
   assign pl_vld      = pl_vld_q;
   assign pl_sop      = pl_sop_q;
   assign pl_eop      = pl_eop_q;
   assign chk_done    = done_q;
   assign chk_ok      = ok_q;
   assign chk_err_len = err_len_q;

`ifdef CRC16_CHK_ERR_CNT_EN
   logic [15:0] err_cnt_q;

   // Saturating failed-frame counter, updated alongside the status strobe.
   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         err_cnt_q <= 16'h0000;
      end else if (done_d && !ok_d && err_cnt_q != 16'hFFFF) begin
         err_cnt_q <= err_cnt_q + 16'h0001;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc16_frame_chk.sv
// Self-checking bench for crc16_frame_chk: a per-cycle vector table for the directed
// corner cases, then a randomized word stream checked against a frame-level model.
module tb_crc16_frame_chk;

   localparam int TB_MAX = 4;

   logic        clk_sys = 1'b0;
   logic        rst_sys = 1'b1;
   logic [15:0] rx_din  = 16'h0000;
   logic        rx_vld  = 1'b0;
   logic        rx_sop  = 1'b0;
   logic        rx_eop  = 1'b0;
   logic [15:0] pl_dout;
   logic        pl_vld, pl_sop, pl_eop;
   logic        chk_done, chk_ok, chk_err_len;
`ifdef CRC16_CHK_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   crc16_frame_chk #(.MAX_WORDS(TB_MAX)) dut (
      .clk_sys     (clk_sys),
      .rst_sys     (rst_sys),
      .rx_din      (rx_din),
      .rx_vld      (rx_vld),
      .rx_sop      (rx_sop),
      .rx_eop      (rx_eop),
      .pl_dout     (pl_dout),
      .pl_vld      (pl_vld),
      .pl_sop      (pl_sop),
      .pl_eop      (pl_eop),
      .chk_done    (chk_done),
      .chk_ok      (chk_ok),
      .chk_err_len (chk_err_len)
`ifdef CRC16_CHK_ERR_CNT_EN
      ,
      .err_cnt     (err_cnt)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;
   int exp_err = 0;

   typedef struct {
      logic        rst, vld, sop, eop;
      logic [15:0] din;
      logic        e_vld, e_sop, e_eop;
      logic [15:0] e_dout;
      logic        e_done, e_ok, e_err;
   } vec_t;

   vec_t vecs[$];

   // Frame-level reference state
   logic [15:0] frm[$];
   bit          in_frm = 1'b0;
   logic [17:0] exp_pl[$];
   logic [17:0] act_pl[$];
   logic [1:0]  exp_st[$];
   logic [1:0]  act_st[$];

   // CRC of a whole message from the bit-serial definition.
   function automatic logic [15:0] crc_msg(input logic [15:0] w[$]);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (w[k]) begin
         for (int b = 15; b >= 0; b--) begin
            fb = c[15] ^ w[k][b];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
      end
      return c;
   endfunction

   function automatic void add(input logic rst, input logic vld, input logic sop, input logic eop,
                               input logic [15:0] din,
                               input logic ev, input logic es, input logic ee, input logic [15:0] ed,
                               input logic edn, input logic eok, input logic eer);
      vec_t v;
      v.rst = rst; v.vld = vld; v.sop = sop; v.eop = eop; v.din = din;
      v.e_vld = ev; v.e_sop = es; v.e_eop = ee; v.e_dout = ed;
      v.e_done = edn; v.e_ok = eok; v.e_err = eer;
      vecs.push_back(v);
   endfunction

   task automatic check_row(input int idx, input vec_t v);
      logic good;
      good = (pl_vld == v.e_vld) && (pl_sop == v.e_sop) && (pl_eop == v.e_eop) &&
             (chk_done == v.e_done) &&
             (!(v.e_done || v.rst) || (chk_ok == v.e_ok && chk_err_len == v.e_err)) &&
             (!(v.e_vld || v.rst) || pl_dout == v.e_dout);
      checks++;
      if (!good) begin
         errors++;
         $display("FAIL row%0d: got vld=%b sop=%b eop=%b dout=%h done=%b ok=%b err=%b want vld=%b sop=%b eop=%b dout=%h done=%b ok=%b err=%b",
                  idx, pl_vld, pl_sop, pl_eop, pl_dout, chk_done, chk_ok, chk_err_len,
                  v.e_vld, v.e_sop, v.e_eop, v.e_dout, v.e_done, v.e_ok, v.e_err);
      end else begin
         $display("row%0d vld=%b sop=%b eop=%b dout=%h done=%b ok=%b err=%b ok",
                  idx, pl_vld, pl_sop, pl_eop, pl_dout, chk_done, chk_ok, chk_err_len);
      end
      if (v.rst) exp_err = 0;
      else if (v.e_done && !v.e_ok && exp_err < 65535) exp_err++;
`ifdef CRC16_CHK_ERR_CNT_EN
      checks++;
      if (err_cnt != 16'(exp_err)) begin
         errors++;
         $display("FAIL err_cnt row%0d: got %0d want %0d", idx, err_cnt, exp_err);
      end
`endif
   endtask

   function automatic void push_status(input logic ok, input logic err);
      exp_st.push_back({ok, err});
      if (!ok && exp_err < 65535) exp_err++;
   endfunction

   function automatic void emit_frame(input int n);
      for (int k = 0; k < n; k++) exp_pl.push_back({k == 0, k == n - 1, frm[k]});
   endfunction

   // Reference behaviour for one accepted word; idle and drop behave alike here.
   function automatic void model_word(input logic sop, input logic eop, input logic [15:0] din);
      if (!in_frm) begin
         if (sop) begin
            if (eop) push_status(1'b0, 1'b1);
            else begin frm.delete(); frm.push_back(din); in_frm = 1'b1; end
         end
      end else if (sop) begin
         emit_frame(frm.size());
         push_status(1'b0, 1'b1);
         if (eop) in_frm = 1'b0;
         else begin frm.delete(); frm.push_back(din); end
      end else if (eop) begin
         emit_frame(frm.size());
         frm.push_back(din);
         push_status(crc_msg(frm) == 16'h0000, 1'b0);
         in_frm = 1'b0;
      end else begin
         frm.push_back(din);
         if (frm.size() == TB_MAX) begin
            emit_frame(TB_MAX - 1);
            push_status(1'b0, 1'b1);
            in_frm = 1'b0;
         end
      end
   endfunction

   // One clock of the random phase: sample outputs just after the edge.
   task automatic rnd_cycle();
      @(posedge clk_sys);
      #1;
      if (pl_vld) act_pl.push_back({pl_sop, pl_eop, pl_dout});
      if (chk_done) act_st.push_back({chk_ok, chk_err_len});
      if (pl_eop || (chk_done && pl_vld)) begin
         checks++;
         if (pl_eop != chk_done) begin
            errors++;
            $display("FAIL eop_done_align: got pl_eop=%b chk_done=%b want equal", pl_eop, chk_done);
         end
      end
      @(negedge clk_sys);
   endtask

   initial begin
      logic [15:0] good_crc;
      logic [15:0] tmp[$];
      logic [15:0] wq[$];
      int          len, n;

      tmp.push_back(16'h1111); tmp.push_back(16'h2222); tmp.push_back(16'h3333);
      good_crc = crc_msg(tmp);

      //  rst vld sop eop din       | vld sop eop dout      done ok err
      add(1, 0, 0, 0, 16'h0000,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(1, 0, 0, 0, 16'h0000,    0, 0, 0, 16'h0000,   0, 0, 0);
      // good two-word frame
      add(0, 1, 1, 0, 16'h0000,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 1, 0, 1, 16'h1D0F,    1, 1, 1, 16'h0000,   1, 1, 0);
      // bad CRC
      add(0, 1, 1, 0, 16'h0000,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 1, 0, 1, 16'h1D0E,    1, 1, 1, 16'h0000,   1, 0, 0);
      // single-word frame
      add(0, 1, 1, 1, 16'h1234,    0, 0, 0, 16'h0000,   1, 0, 1);
      // words outside any frame
      add(0, 1, 0, 0, 16'hBEEF,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 1, 0, 1, 16'hBEEF,    0, 0, 0, 16'h0000,   0, 0, 0);
      // six words against a four-word limit
      add(0, 1, 1, 0, 16'hA001,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 1, 0, 0, 16'hA002,    1, 1, 0, 16'hA001,   0, 0, 0);
      add(0, 1, 0, 0, 16'hA003,    1, 0, 0, 16'hA002,   0, 0, 0);
      add(0, 1, 0, 0, 16'hA004,    1, 0, 1, 16'hA003,   1, 0, 1);
      add(0, 1, 0, 0, 16'hA005,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 1, 0, 1, 16'hA006,    0, 0, 0, 16'h0000,   0, 0, 0);
      // maximum-length good frame
      add(0, 1, 1, 0, 16'h1111,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 1, 0, 0, 16'h2222,    1, 1, 0, 16'h1111,   0, 0, 0);
      add(0, 1, 0, 0, 16'h3333,    1, 0, 0, 16'h2222,   0, 0, 0);
      add(0, 1, 0, 1, good_crc,    1, 0, 1, 16'h3333,   1, 1, 0);
      // restart on word 3
      add(0, 1, 1, 0, 16'h5555,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 1, 0, 0, 16'h6666,    1, 1, 0, 16'h5555,   0, 0, 0);
      add(0, 1, 1, 0, 16'h0000,    1, 0, 1, 16'h6666,   1, 0, 1);
      add(0, 1, 0, 1, 16'h1D0F,    1, 1, 1, 16'h0000,   1, 1, 0);
      // gaps between words, junk on sop/eop while invalid
      add(0, 1, 1, 0, 16'h0000,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 0, 1, 1, 16'hFFFF,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 0, 1, 1, 16'hFFFF,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 0, 1, 1, 16'hFFFF,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 1, 0, 1, 16'h1D0F,    1, 1, 1, 16'h0000,   1, 1, 0);
      // reset in the middle of a frame
      add(0, 1, 1, 0, 16'h0000,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 1, 0, 0, 16'h1111,    1, 1, 0, 16'h0000,   0, 0, 0);
      add(1, 1, 0, 1, 16'h1D0F,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 1, 0, 1, 16'h1D0F,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 1, 1, 0, 16'h0000,    0, 0, 0, 16'h0000,   0, 0, 0);
      add(0, 1, 0, 1, 16'h1D0F,    1, 1, 1, 16'h0000,   1, 1, 0);

      @(negedge clk_sys);
      foreach (vecs[i]) begin
         rst_sys = vecs[i].rst;
         rx_vld  = vecs[i].vld;
         rx_sop  = vecs[i].sop;
         rx_eop  = vecs[i].eop;
         rx_din  = vecs[i].din;
         @(posedge clk_sys);
         #1;
         check_row(i, vecs[i]);
         @(negedge clk_sys);
      end

      // Randomized frames: varied lengths, mostly-correct CRCs, stray sop, missing eop, gaps.
      rst_sys = 1'b0;
      for (int f = 0; f < 120; f++) begin
         len = $urandom_range(1, 6);
         wq.delete();
         for (int i = 0; i < len; i++) wq.push_back(16'($urandom));
         if (len >= 2 && $urandom_range(0, 2) != 0) begin
            tmp.delete();
            for (int i = 0; i < len - 1; i++) tmp.push_back(wq[i]);
            wq[len-1] = crc_msg(tmp);
         end
         for (int i = 0; i < len; i++) begin
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) begin
               rx_vld = 1'b0;
               rx_sop = 1'($urandom);
               rx_eop = 1'($urandom);
               rx_din = 16'($urandom);
               rnd_cycle();
            end
            rx_vld = 1'b1;
            rx_sop = (i == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 14) == 0);
            rx_eop = (i == len - 1) ? ($urandom_range(0, 7) != 0) : 1'b0;
            rx_din = wq[i];
            model_word(rx_sop, rx_eop, rx_din);
            rnd_cycle();
         end
      end
      rx_vld = 1'b0;
      for (int g = 0; g < 3; g++) rnd_cycle();

      checks++;
      if (act_pl.size() != exp_pl.size()) begin
         errors++;
         $display("FAIL rnd_payload_count: got %0d want %0d", act_pl.size(), exp_pl.size());
      end else $display("rnd payload words %0d ok", act_pl.size());
      n = (act_pl.size() < exp_pl.size()) ? act_pl.size() : exp_pl.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (act_pl[i] != exp_pl[i]) begin
            errors++;
            $display("FAIL rnd_payload[%0d]: got sop/eop/dout=%b/%b/%h want %b/%b/%h", i,
                     act_pl[i][17], act_pl[i][16], act_pl[i][15:0],
                     exp_pl[i][17], exp_pl[i][16], exp_pl[i][15:0]);
         end
      end
      checks++;
      if (act_st.size() != exp_st.size()) begin
         errors++;
         $display("FAIL rnd_status_count: got %0d want %0d", act_st.size(), exp_st.size());
      end else $display("rnd status strobes %0d ok", act_st.size());
      n = (act_st.size() < exp_st.size()) ? act_st.size() : exp_st.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (act_st[i] != exp_st[i]) begin
            errors++;
            $display("FAIL rnd_status[%0d]: got ok/err_len=%b/%b want %b/%b", i,
                     act_st[i][1], act_st[i][0], exp_st[i][1], exp_st[i][0]);
         end
      end
`ifdef CRC16_CHK_ERR_CNT_EN
      checks++;
      if (err_cnt != 16'(exp_err)) begin
         errors++;
         $display("FAIL rnd_err_cnt: got %0d want %0d", err_cnt, exp_err);
      end else $display("rnd err_cnt %0d ok", err_cnt);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
